// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - turns single-cycle event pulses into timed high/low level bursts
//
// Purpose:
//   Each accepted event drives out_signal high for exactly HIGH_TICKS cycles,
//   followed by at least LOW_TICKS cycles low. Events that arrive while a burst
//   is in progress are counted in a saturating pending counter and replayed in
//   order. Back-to-back events produce a seamless HIGH/LOW pattern with no idle
//   cycle in between.
//
// Ports:
//   in_clk       in   1             clock, all logic on rising edge
//   in_rst       in   1             asynchronous active-low reset
//   in_pulse     in   1             event request, one cycle per event
//   out_signal   out  1             stretched level output (registered)
//   out_busy     out  1             high while in the High or Low phase (registered)
//   out_pending  out  PENDING_BITS  queued events not yet started
//   out_overflow out  1             one-cycle flag: an event was dropped (queue full)

`timescale 1ns/1ps

module pulse_stretcher #(
  parameter int HIGH_TICKS   = 50,
  parameter int LOW_TICKS    = 50,
  parameter int PENDING_MAX  = 3,
  parameter int TICK_BITS    = $clog2((HIGH_TICKS > LOW_TICKS) ? HIGH_TICKS : LOW_TICKS) + 1,
  parameter int PENDING_BITS = $clog2(PENDING_MAX) + 1
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_pulse,
  output logic                    out_signal,
  output logic                    out_busy,
  output logic [PENDING_BITS-1:0] out_pending,
  output logic                    out_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // Terminal counts for each phase; the phase counter restarts at 0 on entry.
  localparam logic [TICK_BITS-1:0]    HIGH_LAST = TICK_BITS'(HIGH_TICKS - 1);
  localparam logic [TICK_BITS-1:0]    LOW_LAST  = TICK_BITS'(LOW_TICKS - 1);
  localparam logic [PENDING_BITS-1:0] PEND_FULL = PENDING_BITS'(PENDING_MAX);

  state_e                  state_q, state_d;
  logic [TICK_BITS-1:0]    count_q, count_d;
  logic [PENDING_BITS-1:0] pending_q, pending_d;
  logic                    signal_q, signal_d;
  logic                    busy_q, busy_d;
  logic                    overflow_q, overflow_d;
  logic                    queue_req;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pending_d  = pending_q;
    overflow_d = 1'b0;
    queue_req  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        count_d   = '0;
        pending_d = '0;
        if (in_pulse) begin
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        queue_req = in_pulse;
        if (count_q == HIGH_LAST) begin
          state_d = ST_LOW;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      ST_LOW: begin
        if (count_q == LOW_LAST) begin
          count_d = '0;
          if (pending_q != '0) begin
            // Replay the oldest queued event; a pulse arriving on this same
            // cycle takes its place in the queue, so the count is unchanged.
            state_d   = ST_HIGH;
            pending_d = in_pulse ? pending_q : pending_q - 1'b1;
          end else if (in_pulse) begin
            state_d = ST_HIGH;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          count_d   = count_q + 1'b1;
          queue_req = in_pulse;
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean idle.
        state_d   = ST_IDLE;
        count_d   = '0;
        pending_d = '0;
      end
    endcase

    // Events that cannot start now go to the pending counter, or are dropped
    // and flagged when it is already full.
    if (queue_req) begin
      if (pending_q == PEND_FULL) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end

    // Outputs are registered from the next state so they line up with state_q.
    signal_d = (state_d == ST_HIGH);
    busy_d   = (state_d == ST_HIGH) || (state_d == ST_LOW);
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      pending_q  <= '0;
      signal_q   <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      signal_q   <= signal_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_signal   = signal_q;
  assign out_busy     = busy_q;
  assign out_pending  = pending_q;
  assign out_overflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - scoreboard bench for pulse_stretcher (two parameter sets)

`timescale 1ns/1ps

module tb_pulse_stretcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT1: HIGH=4, LOW=3, PENDING_MAX=3
  logic       rst1 = 1'b0;
  logic       p1   = 1'b0;
  logic       sig1, busy1, ovf1;
  logic [2:0] pend1;

  // DUT2: HIGH=1, LOW=1, PENDING_MAX=2
  logic       rst2 = 1'b0;
  logic       p2   = 1'b0;
  logic       sig2, busy2, ovf2;
  logic [1:0] pend2;

  pulse_stretcher #(.HIGH_TICKS(4), .LOW_TICKS(3), .PENDING_MAX(3)) u_dut1 (
    .in_clk      (clk),
    .in_rst      (rst1),
    .in_pulse    (p1),
    .out_signal  (sig1),
    .out_busy    (busy1),
    .out_pending (pend1),
    .out_overflow(ovf1)
  );

  pulse_stretcher #(.HIGH_TICKS(1), .LOW_TICKS(1), .PENDING_MAX(2)) u_dut2 (
    .in_clk      (clk),
    .in_rst      (rst2),
    .in_pulse    (p2),
    .out_signal  (sig2),
    .out_busy    (busy2),
    .out_pending (pend2),
    .out_overflow(ovf2)
  );

  // Cycle c is the interval following the c-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  typedef struct {
    int cyc;
    int sig;
    int busy;
    int pend;
    int ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  task automatic exp1(input int c, input int s, input int b, input int p, input int o);
    exp_t e;
    e.cyc = c; e.sig = s; e.busy = b; e.pend = p; e.ovf = o;
    q1.push_back(e);
  endtask

  task automatic exp2(input int c, input int s, input int b, input int p, input int o);
    exp_t e;
    e.cyc = c; e.sig = s; e.busy = b; e.pend = p; e.ovf = o;
    q2.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulses1(input int c, input int n);
    wait_cyc(c);
    p1 = 1'b1;
    wait_cyc(c + n);
    p1 = 1'b0;
  endtask

  task automatic pulses2(input int c, input int n);
    wait_cyc(c);
    p2 = 1'b1;
    wait_cyc(c + n);
    p2 = 1'b0;
  endtask

  // Monitor: samples on the falling edge, pops checkpoints due this cycle,
  // and counts burst starts and overflow flags over the whole run.
  exp_t e1, e2;
  logic prev1 = 1'b0, prev2 = 1'b0;
  int   bursts1 = 0, bursts2 = 0, ovfs1 = 0, ovfs2 = 0;

  always @(negedge clk) begin
    while (q1.size() > 0 && q1[0].cyc <= cyc) begin
      e1 = q1.pop_front();
      if (e1.cyc != cyc) begin
        check("dut1 missed checkpoint", cyc, e1.cyc);
      end else begin
        check($sformatf("dut1 c%0d out_signal", cyc), sig1, e1.sig);
        check($sformatf("dut1 c%0d out_busy", cyc), busy1, e1.busy);
        check($sformatf("dut1 c%0d out_pending", cyc), pend1, e1.pend);
        check($sformatf("dut1 c%0d out_overflow", cyc), ovf1, e1.ovf);
      end
    end
    while (q2.size() > 0 && q2[0].cyc <= cyc) begin
      e2 = q2.pop_front();
      if (e2.cyc != cyc) begin
        check("dut2 missed checkpoint", cyc, e2.cyc);
      end else begin
        check($sformatf("dut2 c%0d out_signal", cyc), sig2, e2.sig);
        check($sformatf("dut2 c%0d out_busy", cyc), busy2, e2.busy);
        check($sformatf("dut2 c%0d out_pending", cyc), pend2, e2.pend);
        check($sformatf("dut2 c%0d out_overflow", cyc), ovf2, e2.ovf);
      end
    end
    if (sig1 === 1'b1 && prev1 === 1'b0) bursts1 <= bursts1 + 1;
    if (sig2 === 1'b1 && prev2 === 1'b0) bursts2 <= bursts2 + 1;
    if (ovf1 === 1'b1) ovfs1 <= ovfs1 + 1;
    if (ovf2 === 1'b1) ovfs2 <= ovfs2 + 1;
    prev1 <= sig1;
    prev2 <= sig2;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // DUT1 expectations (cycle, sig, busy, pend, ovf), hand-computed.
    exp1(1, 0, 0, 0, 0);                                   // in reset
    // single pulse at 10: high 11..14, low 15..17, idle 18
    exp1(10, 0, 0, 0, 0); exp1(11, 1, 1, 0, 0); exp1(14, 1, 1, 0, 0);
    exp1(15, 0, 1, 0, 0); exp1(17, 0, 1, 0, 0); exp1(18, 0, 0, 0, 0);
    // pulses 30,32,33: bursts at 31, 38, 45; idle 52
    exp1(33, 1, 1, 1, 0); exp1(34, 1, 1, 2, 0); exp1(37, 0, 1, 2, 0);
    exp1(38, 1, 1, 1, 0); exp1(44, 0, 1, 1, 0); exp1(45, 1, 1, 0, 0);
    exp1(51, 0, 1, 0, 0); exp1(52, 0, 0, 0, 0);
    // pulses 60..65: three queued, two dropped, bursts at 61,68,75,82
    exp1(62, 1, 1, 1, 0); exp1(64, 1, 1, 3, 0); exp1(65, 0, 1, 3, 1);
    exp1(66, 0, 1, 3, 1); exp1(67, 0, 1, 3, 0); exp1(68, 1, 1, 2, 0);
    exp1(75, 1, 1, 1, 0); exp1(82, 1, 1, 0, 0); exp1(88, 0, 1, 0, 0);
    exp1(89, 0, 0, 0, 0);
    // pulse on final low cycle 107 with nothing pending
    exp1(107, 0, 1, 0, 0); exp1(108, 1, 1, 0, 0); exp1(111, 1, 1, 0, 0);
    exp1(112, 0, 1, 0, 0); exp1(115, 0, 0, 0, 0);
    // pulse on final low cycle 127 with two pending
    exp1(123, 1, 1, 2, 0); exp1(127, 0, 1, 2, 0); exp1(128, 1, 1, 2, 0);
    exp1(135, 1, 1, 1, 0); exp1(142, 1, 1, 0, 0); exp1(149, 0, 0, 0, 0);
    // reset asserted during cycle 163 with two pending; no stale bursts
    exp1(162, 1, 1, 1, 0); exp1(163, 0, 0, 0, 0); exp1(170, 0, 0, 0, 0);
    exp1(180, 0, 0, 0, 0); exp1(186, 1, 1, 0, 0); exp1(193, 0, 0, 0, 0);

    // DUT2 expectations: pulses every cycle 10..15, HIGH=1, LOW=1, max 2.
    exp2(1, 0, 0, 0, 0);
    exp2(10, 0, 0, 0, 0); exp2(11, 1, 1, 0, 0); exp2(12, 0, 1, 1, 0);
    exp2(13, 1, 1, 1, 0); exp2(14, 0, 1, 2, 0); exp2(15, 1, 1, 2, 0);
    exp2(16, 0, 1, 2, 1); exp2(17, 1, 1, 1, 0); exp2(18, 0, 1, 1, 0);
    exp2(19, 1, 1, 0, 0); exp2(20, 0, 1, 0, 0); exp2(21, 0, 0, 0, 0);
    exp2(25, 0, 0, 0, 0);

    fork
      begin
        wait_cyc(2);
        rst1 = 1'b1;
        pulses1(10, 1);
        pulses1(30, 1);
        pulses1(32, 2);
        pulses1(60, 6);
        pulses1(100, 1);
        pulses1(107, 1);
        pulses1(120, 3);
        pulses1(127, 1);
        pulses1(160, 3);
        wait_cyc(163);
        rst1 = 1'b0;
        #1;
        check("dut1 async reset out_signal", sig1, 0);
        check("dut1 async reset out_busy", busy1, 0);
        check("dut1 async reset out_pending", pend1, 0);
        check("dut1 async reset out_overflow", ovf1, 0);
        wait_cyc(166);
        rst1 = 1'b1;
        pulses1(185, 1);
      end
      begin
        wait_cyc(2);
        rst2 = 1'b1;
        pulses2(10, 6);
      end
    join

    wait_cyc(200);
    check("dut1 unvisited checkpoints", q1.size(), 0);
    check("dut2 unvisited checkpoints", q2.size(), 0);
    check("dut1 burst count", bursts1, 16);
    check("dut1 overflow count", ovfs1, 2);
    check("dut2 burst count", bursts2, 5);
    check("dut2 overflow count", ovfs2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
